// File: rtl/binary_to_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Optional BCD_LEADING_BLANK_EN adds a registered leading-zero blank mask.
module binary_to_bcd_converter #(
    parameter int INPUT_WIDTH = 14,
    parameter int NUM_DIGITS  = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [INPUT_WIDTH-1:0]    binary,
    output logic                      busy,
    output logic                      done,
    output logic [4*NUM_DIGITS-1:0]   bcd,
    output logic                      overflow
`ifdef BCD_LEADING_BLANK_EN
    ,
    output logic [NUM_DIGITS-1:0]     blank
`endif
);

    localparam int BW = 4 * NUM_DIGITS;
    localparam int SW = BW + 4;
    localparam int CW = $clog2(INPUT_WIDTH + 1);

    function automatic longint unsigned max_value();
        longint unsigned v;
        v = 1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            v = v * 10;
        end
        return v - 1;
    endfunction

    localparam longint unsigned MAX_VAL = max_value();
    localparam logic [BW-1:0] NINES = {NUM_DIGITS{4'h9}};

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                 state_q, state_d;
    logic [INPUT_WIDTH-1:0] shift_q, shift_d;
    logic [SW-1:0]          scratch_q, scratch_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   ovfp_q, ovfp_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [BW-1:0]          bcd_q, bcd_d;
    logic                   overflow_q, overflow_d;
    logic [SW-1:0]          adj;
    logic [SW-1:0]          shifted;
    logic                   last;
    logic                   in_ovf;

`ifdef BCD_LEADING_BLANK_EN
    logic [NUM_DIGITS-1:0]  blank_q, blank_d;

    // Digit i blanks only when it and every higher digit are zero.
    function automatic logic [NUM_DIGITS-1:0] blank_of(
        input logic [BW-1:0] d,
        input logic          ovf
    );
        logic [NUM_DIGITS-1:0] b;
        logic                  zero;
        b    = '0;
        zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero = zero && (d[4*i +: 4] == 4'd0);
            b[i] = zero && !ovf;
        end
        return b;
    endfunction

    assign blank = blank_q;
`endif

    assign last   = (cnt_q == CW'(INPUT_WIDTH - 1));
    assign in_ovf = (64'(binary) > 64'(MAX_VAL));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = SHIFT;
            SHIFT: if (last)  state_d = IDLE;
        endcase
    end

    // Add-3 on every scratch nibble, then shift the next input bit in.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < SW / 4; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end
        shifted = {adj[SW-2:0], shift_q[INPUT_WIDTH-1]};
    end

    always_comb begin
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovfp_d     = ovfp_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
`ifdef BCD_LEADING_BLANK_EN
        blank_d    = blank_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d   = binary;
                    scratch_d = '0;
                    cnt_d     = '0;
                    ovfp_d    = in_ovf;
                    busy_d    = 1'b1;
                end
            end
            SHIFT: begin
                scratch_d = shifted;
                shift_d   = {shift_q[INPUT_WIDTH-2:0], 1'b0};
                cnt_d     = cnt_q + CW'(1);
                if (last) begin
                    bcd_d      = ovfp_q ? NINES : shifted[BW-1:0];
                    overflow_d = ovfp_q;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
`ifdef BCD_LEADING_BLANK_EN
                    blank_d    = blank_of(shifted[BW-1:0], ovfp_q);
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovfp_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
`ifdef BCD_LEADING_BLANK_EN
            blank_q    <= '0;
`endif
        end else begin
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovfp_q     <= ovfp_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
`ifdef BCD_LEADING_BLANK_EN
            blank_q    <= blank_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_binary_to_bcd_converter.sv
// Scoreboard bench for binary_to_bcd_converter: decimal reference model,
// monitor pops expectations on every done pulse and checks hold in between.
module tb_binary_to_bcd_converter;

    logic        clock;
    logic        reset;
    logic        start;
    logic [13:0] binary;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        overflow;
`ifdef BCD_LEADING_BLANK_EN
    logic [3:0]  blank;
`endif

    binary_to_bcd_converter dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .binary   (binary),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .overflow (overflow)
`ifdef BCD_LEADING_BLANK_EN
        ,
        .blank    (blank)
`endif
    );

    typedef struct packed {
        logic [15:0] bcd;
        logic        ovf;
        logic [3:0]  blank;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Decimal reference: saturate at 9999, split digits by division.
    function automatic exp_t model(input int v);
        exp_t e;
        int   c;
        int   p;
        c     = (v > 9999) ? 9999 : v;
        e.ovf = (v > 9999);
        e.bcd = '0;
        for (int i = 0; i < 4; i++) begin
            e.bcd[4*i +: 4] = 4'(c % 10);
            c = c / 10;
        end
        e.blank = '0;
        p = 1;
        for (int i = 1; i < 4; i++) begin
            p = p * 10;
            e.blank[i] = !e.ovf && (v < p);
        end
        return e;
    endfunction

    // Monitor: pop on done, otherwise outputs must hold the last result.
    exp_t held;
    logic prev_done;
    initial begin
        held      = '0;
        prev_done = 1'b0;
        forever begin
            @(negedge clock);
            #1;
            if (reset) begin
                held      = '0;
                prev_done = 1'b0;
            end else if (done) begin
                check("done_single_cycle", 32'(prev_done), 32'd0);
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    held = sb.pop_front();
                    check("bcd", 32'(bcd), 32'(held.bcd));
                    check("overflow", 32'(overflow), 32'(held.ovf));
`ifdef BCD_LEADING_BLANK_EN
                    check("blank", 32'(blank), 32'(held.blank));
`endif
                end
                prev_done = 1'b1;
            end else begin
                check("bcd_hold", 32'(bcd), 32'(held.bcd));
                check("overflow_hold", 32'(overflow), 32'(held.ovf));
`ifdef BCD_LEADING_BLANK_EN
                check("blank_hold", 32'(blank), 32'(held.blank));
`endif
                prev_done = 1'b0;
            end
        end
    end

    task automatic wait_done(output int k);
        k = 0;
        forever begin
            @(negedge clock);
            k++;
            if (done) break;
            if (k >= 40) begin
                check("done_timeout", 32'd1, 32'd0);
                break;
            end
        end
    endtask

    task automatic do_conv(input int v);
        int k;
        @(negedge clock);
        binary = 14'(v);
        start  = 1'b1;
        sb.push_back(model(v));
        @(negedge clock);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        wait_done(k);
        check("latency", 32'(k), 32'd14);
        check("busy_at_done", 32'(busy), 32'd0);
    endtask

    initial begin
        int k;
        reset  = 1'b1;
        start  = 1'b0;
        binary = '0;
        repeat (2) @(negedge clock);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_bcd", 32'(bcd), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;

        do_conv(1234);
        repeat (3) @(negedge clock);
        do_conv(0);
        do_conv(9999);
        do_conv(12000);

        // Start while busy is ignored; start held through done is accepted.
        @(negedge clock);
        binary = 14'd42;
        start  = 1'b1;
        sb.push_back(model(42));
        @(negedge clock);
        start = 1'b0;
        k = 0;
        while (!done && k < 40) begin
            if (k == 7) begin
                binary = 14'd555;
                start  = 1'b1;
            end else if (k == 8) begin
                start = 1'b0;
            end else if (k == 13) begin
                binary = 14'd77;
                start  = 1'b1;
                sb.push_back(model(77));
            end
            @(negedge clock);
            k++;
        end
        check("latency_42", 32'(k), 32'd14);
        check("start_held_at_done", 32'(start), 32'd1);
        @(negedge clock);
        start = 1'b0;
        check("busy_back_to_back", 32'(busy), 32'd1);
        wait_done(k);
        check("latency_77", 32'(k), 32'd14);

        // Reset mid-conversion aborts without a done pulse.
        @(negedge clock);
        binary = 14'd8765;
        start  = 1'b1;
        sb.push_back(model(8765));
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        sb.delete();
        #2;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_bcd", 32'(bcd), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        do_conv(305);

        do_conv(10000);
        do_conv(16383);
        do_conv(1);
        for (int i = 0; i < 60; i++) begin
            do_conv(int'($urandom_range(0, 16383)));
        end

        repeat (3) @(negedge clock);
        check("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
